uart_tx_sequencer: RTL and testbench
====================================

Name: uart_tx_sequencer

Overview:
- Transmit-side controller that turns the one-clock bit-period tick from the baud rate generator (next_bit) into a UART frame on txd: start, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Also owns the generator's baud_sel input. A requested baud step is applied only while the line is idle, and the sequencer resynchronises to the new tick before it accepts another frame.
- Sits between the host write interface and the baud rate generator / TX pad.

Parameters:
- DATA_W, 8, data bits per frame (fixed 8 in this revision; counter width 3).
- IDLE_LEVEL, 1'b1, txd level when idle and during stop bits.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- next_bit  in  1  bit-period tick from the baud generator, one clock wide.
- tx_data  in  8  byte to send, sampled on accept.
- tx_valid  in  1  host has a byte.
- tx_ready  out  1  sequencer can accept; accept = tx_valid & tx_ready.
- parity_en  in  1  insert parity bit; sampled on accept.
- parity_odd  in  1  1 = odd parity, 0 = even; sampled on accept.
- stop2  in  1  two stop bits; sampled on accept.
- baud_req  in  1  one-clock request to step the baud rate.
- baud_sel  out  1  registered one-clock pulse to the generator's baud_sel input.
- txd  out  1  serial output, registered.
- busy  out  1  high from accept until the end of the last stop bit.
- tx_done  out  1  one-clock pulse when a frame completes.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; txd = 1; tx_ready = 1; busy = 0; tx_done = 0; baud_sel = 0; baud_pend = 0.
  - All counters and shift register = 0.
- States: IDLE, ALIGN, START, DATA, PARITY, STOP, BAUD_PULSE, BAUD_SYNC.
- IDLE:
  - tx_ready = ~baud_pend.
  - If baud_pend, go to BAUD_PULSE. Pending baud change has priority over a new frame.
  - Else on accept: latch tx_data into the shift register, latch the config bits, precompute parity = ^tx_data ^ parity_odd, set busy, go to ALIGN.
- ALIGN: txd stays 1. On next_bit, txd <= 0 and go to START. This aligns the start-bit edge to the baud grid.
- Bit advance: in every following state, txd changes only on the clock edge where next_bit = 1. One bit period is tick to tick.
- START: on tick, txd <= shift[0], shift right, bit_cnt = 0, go to DATA.
- DATA: on tick, bit_cnt++.
  - If bit_cnt was 7 and parity_en: txd <= parity, go to PARITY.
  - If bit_cnt was 7 and not parity_en: txd <= 1, stop_cnt = 0, go to STOP.
  - Otherwise txd <= next shift bit.
- PARITY: on tick, txd <= 1, go to STOP.
- STOP: on tick, finish if stop_cnt == stop2, else stop_cnt++.
  - Finish means: tx_done pulses for that one cycle, busy <= 0, go to IDLE.
  - Back-to-back frames: tx_ready rises in the cycle after tx_done, and a new frame re-aligns in ALIGN.
  - Frame length in ticks = 10 + parity_en + stop2, not counting ALIGN.
- baud_req handling:
  - baud_req in any state sets baud_pend.
  - A second request while already pending is merged into the first: one step only.
- BAUD_PULSE: baud_sel = 1 for exactly one clock, clear baud_pend, go to BAUD_SYNC.
- BAUD_SYNC:
  - tx_ready = 0, txd = 1.
  - Wait for the first next_bit after the pulse, then go to IDLE. This discards any tick already in flight from the old modulus.
- Config and data inputs are ignored outside the accept cycle.
- next_bit in IDLE is ignored.
- Reset mid-frame: txd returns to 1 immediately (asynchronous); the partial frame is abandoned and no tx_done is issued.
- baud_req coincident with the finishing STOP tick: frame completes normally, then BAUD_PULSE next.

Decomposition:
- Shared package uart_pkg: state encoding constants, DATA_W, IDLE_LEVEL.
  - Receiver and other sequencers reuse these.
- One natural sub-module: uart_parity_calc (8-bit XOR reduction with odd/even select).
  - Inline is acceptable; the frame sequencer stays a single FSM.

Test Plan:
- next_bit every 4 clocks, send 0xA5 with parity_en = 0, stop2 = 0:
  - txd = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks.
  - tx_done pulses once; busy is high for 40 clocks plus align.
- 0x07 with parity_en = 1, parity_odd = 0, stop2 = 1:
  - Parity bit = 1, two stop bits, 12 bit periods total.
  - Repeat with parity_odd = 1: parity bit = 0.
- tx_valid held high with 0x00 then 0xFF:
  - Exactly two accepts and two tx_done pulses.
  - Line returns to 1 between frames; no bit is dropped or duplicated.
- baud_req pulsed mid-DATA:
  - baud_sel stays 0 until the frame's tx_done, then pulses exactly 1 clock.
  - tx_ready stays 0 until the first next_bit after the pulse.
- Two baud_req pulses while busy: exactly one baud_sel pulse.
- reset_n asserted during bit 3 of a frame:
  - txd = 1, tx_ready = 1, busy = 0 immediately; no tx_done.
  - After release, a new byte transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line levels, sequencer state encoding.
package uart_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ALIGN      = 3'd1,
        ST_START      = 3'd2,
        ST_DATA       = 3'd3,
        ST_PARITY     = 3'd4,
        ST_STOP       = 3'd5,
        ST_BAUD_PULSE = 3'd6,
        ST_BAUD_SYNC  = 3'd7
    } tx_state_t;

    // Per-frame options captured at accept time.
    typedef struct packed {
        logic parity_en;
        logic stop2;
    } tx_cfg_t;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity of one data byte; odd = 1 selects odd parity, 0 selects even.
module uart_parity_calc
    import uart_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic              odd,
    output logic              parity_c
);

    // XOR reduction, inverted for odd parity
    assign parity_c = (^data) ^ odd;

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: frames bytes onto txd on the baud tick grid and
// applies baud-rate steps only while the line is idle.
module uart_tx_sequencer
    import uart_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              next_bit,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    input  logic              baud_req,
    output logic              baud_sel,
    output logic              txd,
    output logic              busy,
    output logic              tx_done
);

    tx_state_t             state, state_nxt;
    logic [DATA_W-1:0]     shift, shift_nxt;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic                  stop_cnt, stop_cnt_nxt;
    tx_cfg_t               cfg, cfg_nxt;
    logic                  parity, parity_nxt;
    logic                  baud_pend, baud_pend_nxt;
    logic                  txd_nxt;
    logic                  tx_ready_nxt;
    logic                  busy_nxt;
    logic                  tx_done_nxt;
    logic                  baud_sel_nxt;
    logic                  accept_c;
    logic                  parity_in_c;

    assign accept_c = tx_valid & tx_ready;

    // Parity of the incoming byte, latched together with the data on accept
    uart_parity_calc u_parity (
        .data     (tx_data),
        .odd      (parity_odd),
        .parity_c (parity_in_c)
    );

    // State, datapath and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            cfg       <= '0;
            parity    <= 1'b0;
            baud_pend <= 1'b0;
            txd       <= IDLE_LEVEL;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            baud_sel  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            stop_cnt  <= stop_cnt_nxt;
            cfg       <= cfg_nxt;
            parity    <= parity_nxt;
            baud_pend <= baud_pend_nxt;
            txd       <= txd_nxt;
            tx_ready  <= tx_ready_nxt;
            busy      <= busy_nxt;
            tx_done   <= tx_done_nxt;
            baud_sel  <= baud_sel_nxt;
        end
    end

    // Next-state and next-output logic; the line only moves on next_bit edges
    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift;
        bit_cnt_nxt   = bit_cnt;
        stop_cnt_nxt  = stop_cnt;
        cfg_nxt       = cfg;
        parity_nxt    = parity;
        txd_nxt       = txd;
        busy_nxt      = busy;
        tx_done_nxt   = 1'b0;
        // Requests accumulate in any state; repeats merge into one step
        baud_pend_nxt = baud_pend | baud_req;

        case (state)
            ST_IDLE: begin
                txd_nxt = IDLE_LEVEL;
                if (baud_pend) begin
                    state_nxt = ST_BAUD_PULSE;
                end else if (accept_c) begin
                    shift_nxt         = tx_data;
                    cfg_nxt.parity_en = parity_en;
                    cfg_nxt.stop2     = stop2;
                    parity_nxt        = parity_in_c;
                    busy_nxt          = 1'b1;
                    state_nxt         = ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                if (next_bit) begin
                    txd_nxt   = ~IDLE_LEVEL;
                    state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (next_bit) begin
                    txd_nxt     = shift[0];
                    shift_nxt   = {1'b0, shift[DATA_W-1:1]};
                    bit_cnt_nxt = '0;
                    state_nxt   = ST_DATA;
                end
            end

            ST_DATA: begin
                if (next_bit) begin
                    bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
                        if (cfg.parity_en) begin
                            txd_nxt   = parity;
                            state_nxt = ST_PARITY;
                        end else begin
                            txd_nxt      = IDLE_LEVEL;
                            stop_cnt_nxt = 1'b0;
                            state_nxt    = ST_STOP;
                        end
                    end else begin
                        txd_nxt   = shift[0];
                        shift_nxt = {1'b0, shift[DATA_W-1:1]};
                    end
                end
            end

            ST_PARITY: begin
                if (next_bit) begin
                    txd_nxt      = IDLE_LEVEL;
                    stop_cnt_nxt = 1'b0;
                    state_nxt    = ST_STOP;
                end
            end

            ST_STOP: begin
                if (next_bit) begin
                    if (stop_cnt == cfg.stop2) begin
                        tx_done_nxt = 1'b1;
                        busy_nxt    = 1'b0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        stop_cnt_nxt = stop_cnt + 1'b1;
                    end
                end
            end

            ST_BAUD_PULSE: begin
                // Only a request arriving during the pulse itself survives
                baud_pend_nxt = baud_req;
                state_nxt     = ST_BAUD_SYNC;
            end

            ST_BAUD_SYNC: begin
                // Drop any tick still in flight from the old rate
                txd_nxt = IDLE_LEVEL;
                if (next_bit) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        baud_sel_nxt = (state_nxt == ST_BAUD_PULSE);
        // Ready only after a full cycle of settled idle with nothing pending
        tx_ready_nxt = (state == ST_IDLE) && (state_nxt == ST_IDLE) && !baud_pend_nxt;
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: bit-queue reference model compared every cycle,
// plus literal line captures for hand-computed frames.
module tb_uart_tx_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       next_bit = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
    logic       baud_req;
    logic       baud_sel;
    logic       txd;
    logic       busy;
    logic       tx_done;

    logic baud_req_dir = 1'b0;
    logic baud_req_rnd = 1'b0;
    bit   rand_baud    = 1'b0;
    bit   run_cmp      = 1'b0;
    int   tick_per     = 4;
    int   tick_cnt     = 0;

    int checks = 0;
    int errors = 0;

    int  cyc = 0;
    int  done_cnt = 0;
    int  sel_cnt = 0;
    int  acc_cnt = 0;
    int  last_done_cyc = 0;
    int  last_sel_cyc = 0;
    logic last_tick = 1'b0;
    logic last_busy = 1'b0;

    assign baud_req = baud_req_dir | baud_req_rnd;

    uart_tx_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .next_bit   (next_bit),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .baud_req   (baud_req),
        .baud_sel   (baud_sel),
        .txd        (txd),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Baud tick source: one-clock pulse every tick_per clocks
    always @(negedge clock) begin
        if (tick_cnt >= tick_per - 1) begin
            tick_cnt = 0;
            next_bit = 1'b1;
        end else begin
            tick_cnt++;
            next_bit = 1'b0;
        end
    end

    always @(negedge clock) baud_req_rnd = rand_baud && ($urandom_range(0, 39) == 0);

    // Event monitors
    always @(negedge clock) begin
        cyc++;
        if (reset_n) begin
            if (tx_done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (baud_sel) begin
                sel_cnt++;
                last_sel_cyc = cyc;
            end
        end
    end

    always @(posedge clock) begin
        last_tick <= next_bit;
        last_busy <= busy;
        if (reset_n && tx_valid && tx_ready) acc_cnt++;
    end

    // Reference model: a frame is a queue of line levels popped one per tick
    typedef enum {M_IDLE, M_ALIGN, M_SEND, M_PULSE, M_SYNC} mmode_t;
    mmode_t m_mode = M_IDLE;
    bit m_txd = 1'b1, m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_sel = 1'b0, m_pend = 1'b0;
    bit m_bits[$];

    always @(posedge clock or negedge reset_n) begin : model
        mmode_t nm;
        bit acc;
        bit p;
        if (!reset_n) begin
            m_mode = M_IDLE; m_txd = 1'b1; m_ready = 1'b1; m_busy = 1'b0;
            m_done = 1'b0; m_sel = 1'b0; m_pend = 1'b0;
            m_bits.delete();
        end else begin
            nm     = m_mode;
            acc    = tx_valid && m_ready;
            m_done = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (m_pend) begin
                        nm = M_PULSE;
                    end else if (acc) begin
                        m_bits.delete();
                        for (int i = 0; i < 8; i++) m_bits.push_back(tx_data[i]);
                        if (parity_en) begin
                            p = (($countones(tx_data) % 2) == 1);
                            if (parity_odd) p = !p;
                            m_bits.push_back(p);
                        end
                        m_bits.push_back(1'b1);
                        if (stop2) m_bits.push_back(1'b1);
                        m_busy = 1'b1;
                        nm = M_ALIGN;
                    end
                end
                M_ALIGN: if (next_bit) begin m_txd = 1'b0; nm = M_SEND; end
                M_SEND: if (next_bit) begin
                    if (m_bits.size() == 0) begin
                        m_done = 1'b1; m_busy = 1'b0; nm = M_IDLE;
                    end else begin
                        m_txd = m_bits.pop_front();
                    end
                end
                M_PULSE: nm = M_SYNC;
                M_SYNC:  if (next_bit) nm = M_IDLE;
                default: nm = M_IDLE;
            endcase
            m_pend  = baud_req || (m_pend && m_mode != M_PULSE);
            m_sel   = (nm == M_PULSE);
            m_ready = (nm == M_IDLE) && (m_mode == M_IDLE) && !m_pend;
            m_mode  = nm;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clock) begin
        if (reset_n && run_cmp) begin
            chk("txd",      32'(txd),      32'(m_txd));
            chk("tx_ready", 32'(tx_ready), 32'(m_ready));
            chk("busy",     32'(busy),     32'(m_busy));
            chk("tx_done",  32'(tx_done),  32'(m_done));
            chk("baud_sel", 32'(baud_sel), 32'(m_sel));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 3000) begin @(negedge clock); n++; end
        chk("ready_timeout", 32'(tx_ready), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!tx_done && n < 3000) begin @(negedge clock); n++; end
        chk("done_timeout", 32'(tx_done), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge just after the accept edge
    task automatic do_accept(input logic [7:0] d, input bit pe, input bit po, input bit s2);
        tx_data = d; parity_en = pe; parity_odd = po; stop2 = s2; tx_valid = 1'b1;
        wait_ready();
        @(negedge clock);
        tx_valid = 1'b0;
        tx_data = 8'($urandom); parity_en = 1'($urandom); parity_odd = 1'($urandom); stop2 = 1'($urandom);
    endtask

    // Records the line level set at each tick edge while the frame is in flight
    task automatic capture(output logic [15:0] cap, output int n, output int bc);
        int c = 0;
        cap = '0; n = 0; bc = 0;
        while (c < 2000) begin
            if (busy) bc++;
            if (last_tick && last_busy && busy && n < 16) begin cap[n] = txd; n++; end
            if (tx_done) break;
            @(negedge clock); c++;
        end
    endtask

    initial begin : main
        logic [15:0] cap;
        int n, bc, d0, a0, s0, cnt;
        reset_n = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_txd",      32'(txd),      32'd1);
        chk("reset_tx_ready", 32'(tx_ready), 32'd1);
        chk("reset_busy",     32'(busy),     32'd0);
        chk("reset_tx_done",  32'(tx_done),  32'd0);
        chk("reset_baud_sel", 32'(baud_sel), 32'd0);
        reset_n = 1'b1; run_cmp = 1'b1;
        repeat (5) @(negedge clock);

        // 0xA5, no parity, one stop bit
        d0 = done_cnt;
        do_accept(8'hA5, 1'b0, 1'b0, 1'b0);
        capture(cap, n, bc);
        chk("a5_bits", 32'(cap[9:0]), 32'h34A);
        chk("a5_len",  32'(n), 32'd10);
        chk("a5_busy_span", 32'(bc >= 41 && bc <= 44), 32'd1);
        repeat (10) @(negedge clock);
        chk("a5_done_count", 32'(done_cnt - d0), 32'd1);

        // 0x07, even parity, two stop bits
        do_accept(8'h07, 1'b1, 1'b0, 1'b1);
        capture(cap, n, bc);
        chk("x07_even_bits", 32'(cap[11:0]), 32'hE0E);
        chk("x07_even_len",  32'(n), 32'd12);
        repeat (8) @(negedge clock);

        // 0x07, odd parity, two stop bits
        do_accept(8'h07, 1'b1, 1'b1, 1'b1);
        capture(cap, n, bc);
        chk("x07_odd_bits", 32'(cap[11:0]), 32'hC0E);
        chk("x07_odd_len",  32'(n), 32'd12);
        repeat (8) @(negedge clock);

        // tx_valid held high across two frames
        d0 = done_cnt; a0 = acc_cnt;
        tx_data = 8'h00; parity_en = 1'b0; stop2 = 1'b0; tx_valid = 1'b1;
        wait_ready();
        @(negedge clock);
        tx_data = 8'hFF;
        @(negedge clock);
        wait_ready();
        @(negedge clock);
        tx_valid = 1'b0;
        wait_done();
        repeat (10) @(negedge clock);
        chk("b2b_dones",   32'(done_cnt - d0), 32'd2);
        chk("b2b_accepts", 32'(acc_cnt - a0),  32'd2);

        // Two baud requests mid-frame: one deferred pulse
        s0 = sel_cnt;
        do_accept(8'h96, 1'b0, 1'b0, 1'b0);
        cnt = 0; n = 0;
        while (cnt < 4 && n < 400) begin
            @(negedge clock); n++;
            if (last_tick && last_busy && busy) cnt++;
        end
        baud_req_dir = 1'b1; @(negedge clock); baud_req_dir = 1'b0;
        repeat (6) @(negedge clock);
        baud_req_dir = 1'b1; @(negedge clock); baud_req_dir = 1'b0;
        chk("baud_held_off", 32'(sel_cnt - s0), 32'd0);
        wait_done();
        repeat (20) @(negedge clock);
        chk("baud_one_pulse", 32'(sel_cnt - s0), 32'd1);
        chk("baud_after_done", 32'(last_sel_cyc == last_done_cyc + 1), 32'd1);

        // Reset during data bit 3
        do_accept(8'hC3, 1'b1, 1'b0, 1'b0);
        cnt = 0; n = 0;
        while (cnt < 5 && n < 400) begin
            @(negedge clock); n++;
            if (last_tick && last_busy && busy) cnt++;
        end
        d0 = done_cnt;
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_txd",      32'(txd),      32'd1);
        chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
        chk("midrst_busy",     32'(busy),     32'd0);
        repeat (3) @(negedge clock);
        chk("midrst_no_done", 32'(tx_done), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        chk("midrst_done_count", 32'(done_cnt - d0), 32'd0);
        do_accept(8'h3C, 1'b0, 1'b0, 1'b0);
        capture(cap, n, bc);
        chk("post_rst_bits", 32'(cap[9:0]), 32'h278);
        chk("post_rst_len",  32'(n), 32'd10);
        repeat (6) @(negedge clock);

        // Randomised frames, tick rates and baud requests against the model
        rand_baud = 1'b1;
        d0 = done_cnt;
        for (int k = 0; k < 40; k++) begin
            tick_per = $urandom_range(2, 6);
            do_accept(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            wait_done();
            repeat ($urandom_range(0, 5)) @(negedge clock);
        end
        rand_baud = 1'b0;
        repeat (40) @(negedge clock);
        chk("random_done_count", 32'(done_cnt - d0), 32'd40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
